// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the two-port RAM arbiter: controller states and
// arbitration-mode encodings.
package ram_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_RUN   = 2'd1,
        ST_LOCK0 = 2'd2,
        ST_LOCK1 = 2'd3
    } state_e;

    localparam int unsigned PRIO_RR    = 0;
    localparam int unsigned PRIO_FIXED = 1;

endpackage

// File: rtl/ram_arbiter_rr_arb2.sv
// Two-input picker: round-robin on a last-grant pointer, or fixed priority
// to input 0. The grant is combinational; only the pointer is stored.
module rr_arb2
    import ram_arbiter_pkg::*;
#(
    parameter int unsigned PRIO = PRIO_RR
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic [1:0] gnt_c_o
);

    logic       last_q;
    logic [1:0] pick;

    // last_q == 1 means port 1 was granted most recently, so port 0 wins a tie
    always_comb begin
        pick = 2'b00;
        case (req_i)
            2'b01:   pick = 2'b01;
            2'b10:   pick = 2'b10;
            2'b11:   pick = ((PRIO == PRIO_FIXED) || last_q) ? 2'b01 : 2'b10;
            default: pick = 2'b00;
        endcase
    end

    assign gnt_c_o = pick & {2{en_i}};

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= 1'b1;
        end else if (|gnt_c_o) begin
            last_q <= gnt_c_o[1];
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port synchronous RAM between a CPU port and a loader port,
// with RMW locking and an optional zero-fill of the whole RAM after reset.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int unsigned DWIDTH         = 16,
    parameter int unsigned AWIDTH         = 12,
    parameter int unsigned WORDS          = 4096,
    parameter int unsigned PRIO           = PRIO_RR,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic              lock0,
    input  logic              lock1,
    input  logic [AWIDTH-1:0] addr0,
    input  logic [AWIDTH-1:0] addr1,
    input  logic [DWIDTH-1:0] d0,
    input  logic [DWIDTH-1:0] d1,
    output logic              ack0,
    output logic              ack1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DWIDTH-1:0] q,
    output logic              busy,
    output logic              ram_load,
    output logic [AWIDTH-1:0] ram_addr,
    output logic [DWIDTH-1:0] ram_d,
    input  logic [DWIDTH-1:0] ram_q
);

    localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(WORDS - 1);

    state_e            state_q;
    logic [AWIDTH-1:0] clr_cnt_q;
    logic [AWIDTH-1:0] ram_addr_q;
    logic [AWIDTH-1:0] ram_addr_d;
    logic              rvalid0_q;
    logic              rvalid1_q;
    logic [1:0]        arb_req;
    logic              arb_en;
    logic [1:0]        gnt;

    // A lock masks the other port out of arbitration entirely
    always_comb begin
        arb_req = 2'b00;
        case (state_q)
            ST_RUN:   arb_req = {req1, req0};
            ST_LOCK0: arb_req = {1'b0, req0};
            ST_LOCK1: arb_req = {req1, 1'b0};
            default:  arb_req = 2'b00;
        endcase
    end

    assign arb_en = ~reset & (state_q != ST_CLEAR);

    rr_arb2 #(
        .PRIO (PRIO)
    ) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req_i   (arb_req),
        .en_i    (arb_en),
        .gnt_c_o (gnt)
    );

    assign ack0 = gnt[0];
    assign ack1 = gnt[1];

    // RAM-side mux; the address holds its last driven value when idle
    always_comb begin
        ram_addr_d = ram_addr_q;
        ram_d      = '0;
        ram_load   = 1'b0;
        if (state_q == ST_CLEAR) begin
            ram_addr_d = clr_cnt_q;
            ram_load   = ~reset;
        end else if (gnt[0]) begin
            ram_addr_d = addr0;
            ram_d      = d0;
            ram_load   = we0;
        end else if (gnt[1]) begin
            ram_addr_d = addr1;
            ram_d      = d1;
            ram_load   = we1;
        end
    end

    assign ram_addr = ram_addr_d;
    assign q        = ram_q;
    assign busy     = (state_q == ST_CLEAR);
    assign rvalid0  = rvalid0_q & ~reset;
    assign rvalid1  = rvalid1_q & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
            clr_cnt_q  <= '0;
            ram_addr_q <= '0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
        end else begin
            ram_addr_q <= ram_addr_d;
            rvalid0_q  <= gnt[0] & ~we0;
            rvalid1_q  <= gnt[1] & ~we1;
            case (state_q)
                ST_CLEAR: begin
                    clr_cnt_q <= clr_cnt_q + AWIDTH'(1);
                    if (clr_cnt_q == LAST_ADDR) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (gnt[0] && lock0) begin
                        state_q <= ST_LOCK0;
                    end else if (gnt[1] && lock1) begin
                        state_q <= ST_LOCK1;
                    end
                end
                // Leave on an unlocked access, or when the owner walks away
                ST_LOCK0: begin
                    if (!lock0 && (gnt[0] || !req0)) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_LOCK1: begin
                    if (!lock1 && (gnt[1] || !req1)) begin
                        state_q <= ST_RUN;
                    end
                end
                default: state_q <= ST_RUN;
            endcase
        end
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares one single-port synchronous RAM (1-cycle registered read, read-before-write, parameters DWIDTH/AWIDTH/WORDS) between two requesters: port 0 (CPU) and port 1 (loader/debug).
- Provides:
  - a req/ack handshake per port;
  - round-robin or fixed-priority arbitration;
  - a lock for atomic read-modify-write;
  - an optional post-reset clear sequence that zeroes every word.
- Sits between the CPU/loader and the RAM instance; the RAM instance itself is external.

Parameters:
- DWIDTH, 16, data word width
- AWIDTH, 12, address width
- WORDS, 4096, RAM depth; clear walks 0..WORDS-1
- PRIO, 0, 0 = round-robin, 1 = port 0 always wins
- CLEAR_ON_RESET, 1, 1 = zero RAM after reset, 0 = go straight to RUN

Ports:
- clk  in  1  clock, all state on posedge
- reset  in  1  synchronous, active-high
- req0, req1  in  1  access request; held with stable we/addr/d until ack
- we0, we1  in  1  1 = write, 0 = read
- lock0, lock1  in  1  keep ownership after this access (RMW)
- addr0, addr1  in  AWIDTH  request address
- d0, d1  in  DWIDTH  write data
- ack0, ack1  out  1  access accepted this cycle (combinational from state + req)
- rvalid0, rvalid1  out  1  read data valid on q (registered, ack+1)
- q  out  DWIDTH  read data, straight from ram_q
- busy  out  1  clear sequence in progress
- ram_load  out  1  to RAM load
- ram_addr  out  AWIDTH  to RAM addr
- ram_d  out  DWIDTH  to RAM d
- ram_q  in  DWIDTH  from RAM q

Behaviour:
- Clock and reset:
  - one clock;
  - reset is synchronous and active-high (clk, reset);
  - while reset is high: ack0/1 = 0, ram_load = 0.
- Registered state after reset:
  - rvalid0/1 = 0;
  - last-grant pointer = 1, so port 0 wins the first tie;
  - clear counter = 0;
  - state = CLEAR if CLEAR_ON_RESET, else RUN;
  - busy = (state == CLEAR).
- States: CLEAR, RUN, LOCK0, LOCK1.
- CLEAR:
  - ram_load = 1, ram_addr = counter, ram_d = 0;
  - counter increments each cycle;
  - the cycle with counter == WORDS-1 writes the last word; the next state is RUN;
  - total WORDS cycles;
  - ack0/1 = 0; requests stay pending, none lost.
- RUN arbitration:
  - one request: granted;
  - both, PRIO=1: port 0;
  - both, PRIO=0: the port not in the last-grant pointer; pointer updates on every grant.
- Granted port p in the same cycle:
  - ackp = 1;
  - ram_addr = addrp, ram_d = dp, ram_load = wep.
- No grant: ram_load = 0; ram_addr holds its previous value (registered); no side effects.
- Read latency:
  - rvalidp = 1 exactly one cycle after a granted read (wep = 0), for one cycle;
  - q = ram_q in that cycle;
  - a granted write produces no rvalid.
- Back-to-back:
  - one access per cycle max;
  - a port may be acked on consecutive cycles;
  - rvalid pulses follow 1:1.
- Lock:
  - a granted access with lockp = 1 moves to LOCKp;
  - in LOCKp only port p is granted, the other is stalled;
  - exit to RUN on the first granted access of p with lockp = 0;
  - p dropping both req and lock also exits (next cycle);
  - the pointer still updates.
- Same-address read-write:
  - the RAM is read-before-write;
  - a read granted on the cycle after a write to the same address sees the new data;
  - the arbiter adds no bypass.
- reset mid-CLEAR: counter restarts at 0.
- reset mid-LOCK: lock dropped; the reset state is entered.
- reset cycle after a read ack: rvalid is suppressed.
- Widths:
  - counter is AWIDTH bits;
  - the terminal compare is against WORDS-1;
  - WORDS must be <= 2^AWIDTH.

Decomposition:
- Shared package:
  - state encoding constants ST_CLEAR, ST_RUN, ST_LOCK0, ST_LOCK1;
  - PRIO encodings PRIO_RR, PRIO_FIXED.
- One natural sub-module: rr_arb2 (2-input round-robin/fixed-priority picker with pointer register; inputs req vector and enable, outputs one-hot grant).
- FSM, clear counter and muxing stay in ram_arbiter.

Test Plan:
- Clear sequence (WORDS=16, AWIDTH=4, CLEAR_ON_RESET=1):
  - stimulus: reset 1 cycle, req0 read addr 3 held;
  - required: busy high exactly 16 cycles, ram_load high for addresses 0..15 with d=0, ack0 on the cycle after busy falls;
  - required: rvalid0 next cycle with q = 0.
- Write then read:
  - stimulus: port 0 write addr 5 = 16'h1234, then read addr 5;
  - required: ack0 on both cycles, rvalid0 one cycle after the read ack, q = 16'h1234.
- Round-robin (PRIO=0):
  - stimulus: req0 and req1 held continuously (reads, addr 1 and 2) for 6 cycles;
  - required: acks alternate 0,1,0,1,0,1;
  - required: rvalid alternates one cycle later with q = mem[1], mem[2].
- Fixed priority (PRIO=1):
  - stimulus: same stimulus;
  - required: ack0 every cycle, ack1 never;
  - required: after req0 drops, ack1 the same cycle.
- Lock RMW:
  - stimulus: port 1 read addr 7 with lock1=1, port 0 requesting throughout; port 1 writes addr 7 = 16'h00FF with lock1=0;
  - required: port 0 not acked until after port 1's write ack;
  - required: port 0 then reads 16'h00FF.
- Reset mid-operation:
  - stimulus: assert reset while in LOCK0 and on the cycle after a read ack;
  - required: no rvalid, state returns to CLEAR, counter restarts at 0.
